// File: rtl/utils.sv
// utils: shared CDB types, widths and source indices (CDB_ROUND_ROBIN_EN selects arbitration policy).
package utils;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {SRC_INT, SRC_MULT, SRC_DIV, SRC_MEM} src_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              branch;
        logic              branch_taken;
    } cdb_submit_data;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction
endpackage

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: one-hot grant over four requests; round-robin when CDB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority div > mult > mem > int.
module cdb_rr_arbiter
    import utils::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant
);
`ifdef CDB_ROUND_ROBIN_EN
    src_e       ptr;
    logic [1:0] idx;
    // Scan farthest-to-nearest so the slot right after ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = 2'(ptr + 2'(k));
            if (req[idx]) grant = 4'(1) << idx;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= SRC_MEM;
        else if (|grant) ptr <= src_e'(oh2idx(grant));
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign grant = req[SRC_DIV]  ? 4'b0100 :
                   req[SRC_MULT] ? 4'b0010 :
                   req[SRC_MEM]  ? 4'b1000 :
                   req[SRC_INT]  ? 4'b0001 : 4'b0000;
`endif
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: serialises four execution-unit results onto the CDB through one-entry holding registers.
// Policy chosen by CDB_ROUND_ROBIN_EN (see cdb_rr_arbiter).
module cdb_arbiter
    import utils::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  cdb_submit_data    i_int_submit,
    input  cdb_submit_data    i_mult_submit,
    input  cdb_submit_data    i_div_submit,
    input  cdb_submit_data    i_mem_submit,
    output logic              o_int_accept,
    output logic              o_mult_accept,
    output logic              o_div_accept,
    output logic              o_mem_accept,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_branch,
    output logic              cdb_branch_taken
);
    cdb_submit_data sub [4];
    cdb_submit_data hold [4];
    cdb_submit_data win;
    logic [3:0]     hold_valid;
    logic [3:0]     grant;
    logic [3:0]     accept;

    assign sub[SRC_INT]  = i_int_submit;
    assign sub[SRC_MULT] = i_mult_submit;
    assign sub[SRC_DIV]  = i_div_submit;
    assign sub[SRC_MEM]  = i_mem_submit;

    // Accept depends only on held state so there is no submit-to-accept path.
    assign accept        = {4{!i_rst}} & (~hold_valid | grant);
    assign o_int_accept  = accept[SRC_INT];
    assign o_mult_accept = accept[SRC_MULT];
    assign o_div_accept  = accept[SRC_DIV];
    assign o_mem_accept  = accept[SRC_MEM];

    always_comb begin
        hold_valid = '0;
        win        = '0;
        for (int i = 0; i < 4; i++) begin
            hold_valid[i] = hold[i].valid;
            if (grant[i]) win = hold[i];
        end
    end

    cdb_rr_arbiter u_arb (
        .clk   (i_clk),
        .rst   (i_rst),
        .req   (hold_valid),
        .grant (grant)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) hold[i] <= '0;
            {cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken} <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sub[i].valid && accept[i]) hold[i] <= sub[i];
                else if (grant[i]) hold[i].valid <= 1'b0;
            end
            {cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken} <= win;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench; per-source driver queues feed the DUT, a negedge monitor checks the CDB.
module tb_cdb_arbiter;
    import utils::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    cdb_submit_data    sub [4];
    logic [3:0]        acc;
    logic              cdb_valid, cdb_branch, cdb_branch_taken;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    cdb_submit_data    qs [4][$];
    cdb_submit_data    exp_q [$];
    cdb_submit_data    e;
    int                checks = 0;
    int                failures = 0;
    bit                streaming = 1'b0;

`ifdef CDB_ROUND_ROBIN_EN
    localparam logic [3:0] CONT_ACC = 4'b0001;
    localparam int         CONT_ORDER [4] = '{0, 1, 2, 3};
`else
    localparam logic [3:0] CONT_ACC = 4'b0100;
    localparam int         CONT_ORDER [4] = '{2, 1, 3, 0};
`endif

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_int_submit     (sub[0]),
        .i_mult_submit    (sub[1]),
        .i_div_submit     (sub[2]),
        .i_mem_submit     (sub[3]),
        .o_int_accept     (acc[0]),
        .o_mult_accept    (acc[1]),
        .o_div_accept     (acc[2]),
        .o_mem_accept     (acc[3]),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .cdb_branch       (cdb_branch),
        .cdb_branch_taken (cdb_branch_taken)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic cdb_submit_data mk(input logic [5:0] t, input logic [31:0] d,
                                          input logic b, input logic k);
        return {1'b1, t, d, b, k};
    endfunction

    function automatic bit busy();
        return qs[0].size() + qs[1].size() + qs[2].size() + qs[3].size() + exp_q.size() != 0;
    endfunction

    always @(negedge clk) begin
        if (cdb_valid) begin
            if (exp_q.size() == 0) fail("unexpected_bcast");
            else begin
                e = exp_q.pop_front();
                check("bcast", 64'({cdb_tag, cdb_data, cdb_branch, cdb_branch_taken}),
                      64'({e.tag, e.data, e.branch, e.branch_taken}));
            end
        end else
            check("idle_zero", 64'({cdb_tag, cdb_data, cdb_branch, cdb_branch_taken}), 64'h0);
    end

    task automatic step(input bit chk = 1'b0, input logic [3:0] want = 4'h0);
        logic [3:0] tk;
        @(negedge clk);
        for (int i = 0; i < 4; i++) sub[i] = qs[i].size() != 0 ? qs[i][0] : '0;
        #1;
        if (chk) check("accepts", 64'(acc), 64'(want));
        if (streaming && sub[1].valid) check("mult_accept_stream", 64'(acc[1]), 64'h1);
        for (int i = 0; i < 4; i++) tk[i] = sub[i].valid && acc[i];
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (tk[i]) void'(qs[i].pop_front());
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && busy(); n++) step();
        repeat (3) step();
        if (busy()) fail("drain_timeout");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) sub[i] = mk(6'(i + 1), 32'hdead, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            #1 check("acc_in_reset", 64'(acc), 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) sub[i] = '0;
        #1 check("acc_after_rst", 64'(acc), 64'hf);

        qs[0].push_back(mk(6'd5, 32'h0000_1234, 1'b0, 1'b0));
        exp_q.push_back(mk(6'd5, 32'h0000_1234, 1'b0, 1'b0));
        drain();

        for (int i = 0; i < 4; i++) qs[i].push_back(mk(6'(i + 1), 32'(32'ha0 + i), 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(6'(CONT_ORDER[i] + 1), 32'(32'ha0 + CONT_ORDER[i]), 1'b0, 1'b0));
        step();
        step(1'b1, CONT_ACC);
        drain();

        qs[3].push_back(mk(6'd7, 32'h77, 1'b1, 1'b1));
        qs[3].push_back(mk(6'd8, 32'h88, 1'b1, 1'b0));
        exp_q.push_back(mk(6'd7, 32'h77, 1'b1, 1'b1));
        exp_q.push_back(mk(6'd8, 32'h88, 1'b1, 1'b0));
        drain();

        streaming = 1'b1;
        for (int i = 0; i < 10; i++) begin
            qs[1].push_back(mk(6'(10 + i), 32'(i), 1'b0, 1'b0));
            exp_q.push_back(mk(6'(10 + i), 32'(i), 1'b0, 1'b0));
        end
        drain();
        streaming = 1'b0;

        for (int i = 0; i < 4; i++) qs[i].push_back(mk(6'(40 + i), 32'hbad0, 1'b0, 1'b0));
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) sub[i] = '0;
        #1 check("acc_mid_reset", 64'(acc), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("acc_post_mid_reset", 64'(acc), 64'hf);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus (CDB) transmitter for the out-of-order core. It collects completed results from the four execution units (int, mult, div, mem) and serialises them onto the single broadcast bus. Only one result is broadcast per cycle. The bus carries tag, data and branch-outcome signals, which the dispatcher, reservation stations and register status table consume. The block also returns a per-unit accept handshake so an execution unit can stall when its result cannot yet be taken.

## Interface
- TAG_W, 6, ROB/RS tag width carried on the CDB
- DATA_W, 32, result data width
- i_clk  in  1  core clock; everything is rising-edge
- i_rst  in  1  synchronous, active-high reset
- i_int_submit  in  struct  cdb_submit_data from the int unit: valid, tag, data, branch, branch_taken
- i_mult_submit  in  struct  same, from the mult unit
- i_div_submit  in  struct  same, from the div unit
- i_mem_submit  in  struct  same, from the mem unit
- o_int_accept  out  1  int result captured at this edge if submit.valid is high
- o_mult_accept  out  1  same, for mult
- o_div_accept  out  1  same, for div
- o_mem_accept  out  1  same, for mem
- cdb_valid  out  1  broadcast valid; single-cycle per result
- cdb_tag  out  TAG_W  tag of the broadcast result
- cdb_data  out  DATA_W  result value
- cdb_branch  out  1  result is a branch resolution
- cdb_branch_taken  out  1  branch outcome; meaningful only when cdb_branch is high

## Operation
- Each source has a one-entry holding register: hold_valid[i] plus a payload.
- accept[i] = !i_rst && (!hold_valid[i] || grant[i]).
- accept depends only on internal state, never on the submit inputs, so there is no combinational path from submit to accept.
- Capture: when submit.valid and accept[i] are both high at an edge, the payload loads into hold[i] and hold_valid[i] is set.
- Capture: when submit.valid is high and accept[i] is low, the unit must hold its submit fields stable.
- If grant[i] and a new capture occur in the same cycle, hold[i] is overwritten with the new payload and stays valid. This is not a double-issue.
- Arbitration: combinational over hold_valid[3:0] with index order int=0, mult=1, div=2, mem=3. At most one grant per cycle.
- Broadcast: the granted payload is registered onto the cdb_* outputs with cdb_valid=1. hold_valid of the granted source clears unless it is refilled in the same cycle.
- Idle cycles, with no grant: cdb_valid=0, and cdb_tag, cdb_data, cdb_branch and cdb_branch_taken are all driven 0.
- CDB consumers cannot stall; no result is ever dropped or duplicated.
- Results from the same source broadcast in submit order. No ordering is guaranteed across sources.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_branch=0, cdb_branch_taken=0. All accepts are 0 while i_rst is high, and 1 in the first cycle after release. hold_valid=0. Round-robin pointer=3 (mem), so int has top priority first.
- Latency: a submit captured at edge N is granted during cycle N+1 at the earliest, with cdb_valid high after edge N+1, i.e. during cycle N+1→N+2.
- Throughput: one broadcast per cycle. A single source can stream one result per cycle when uncontended.
- Reset mid-operation: all held payloads are discarded and no cdb_valid is produced after reset is released.

## Configuration
- CDB_ROUND_ROBIN_EN defined: round-robin arbitration. The search starts at (last_grant+1) mod 4, and the pointer updates to the granted index on each grant.
- CDB_ROUND_ROBIN_EN undefined: fixed priority div > mult > mem > int, chosen so long-latency units retire first. No pointer register exists.

## Structure
- The shared package utils holds the cdb_submit_data struct, the source-index enum (SRC_INT..SRC_MEM) and the TAG_W/DATA_W constants.
- One sub-module, cdb_rr_arbiter: 4-bit request in, one-hot grant out, carrying the pointer and the macro-selected policy.
- Holding registers and the output register live in cdb_arbiter.

## Test plan
- Reset: hold i_rst 2 cycles with all four submits valid → every output is 0 and every accept is 0. One cycle after release all accepts are 1 and cdb_valid stays 0.
- Single result: int submits tag=5, data=0x0000_1234 at edge N → cdb_valid=1, tag=5, data=0x1234 for exactly the cycle after edge N+1, then returns to 0 and all zeros.
- Contention: all four submit in the same cycle with tags 1 (int), 2 (mult), 3 (div), 4 (mem) and stay valid afterwards → round-robin broadcasts tags 1,2,3,4 on four consecutive cycles; fixed priority broadcasts 3,2,4,1. A losing unit's accept is low until it is granted.
- Branch: mem submits tag=7, branch=1, branch_taken=1, then tag=8, branch=1, branch_taken=0 → the CDB shows both in order with the matching branch and taken bits.
- Streaming: mult submits every cycle with tag=10..19 and data=i while the others are idle → ten consecutive broadcasts in order, o_mult_accept constantly 1, no gaps.
- Mid-operation reset: fill all holding registers, then assert i_rst for 1 cycle → no cdb_valid after release and no stale tag ever appears.
